// File: rtl/camera_pwr_pkg.sv
// Shared types and defaults for the camera power-on / power-off sequencers.
// The power-off encoding order is relied on for the cumulative keep masks.
package camera_pwr_pkg;

    localparam int unsigned CNT_W = 32;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t STEP_DELAY_DEF    = 32'd1000000;
    localparam cnt_t XCLR_HOLD_DEF     = 32'd64;
    localparam cnt_t FAULT_TIMEOUT_DEF = 32'd2000000;

    // Power-off states, in sequence order.
    typedef enum logic [2:0] {
        PD_IDLE     = 3'd0,
        PD_INCK_OFF = 3'd1,
        PD_XCLR_OFF = 3'd2,
        PD_V33_OFF  = 3'd3,
        PD_V18_OFF  = 3'd4,
        PD_V12_OFF  = 3'd5,
        PD_DONE     = 3'd6
    } pd_state_e;

    typedef struct packed {
        logic busy;
        logic done;
        logic inck_keep;
        logic xclr_keep;
        logic reg_3v3_keep;
        logic reg_1v8_keep;
        logic reg_1v2_keep;
    } pd_out_t;

    localparam pd_out_t PD_OUT_RST = '{
        busy: 1'b0, done: 1'b0, inck_keep: 1'b1, xclr_keep: 1'b1,
        reg_3v3_keep: 1'b1, reg_1v8_keep: 1'b1, reg_1v2_keep: 1'b1
    };

    // A programmed delay of 0 behaves as 1 cycle.
    function automatic cnt_t eff_delay(input cnt_t d);
        return (d == '0) ? cnt_t'(1) : d;
    endfunction

endpackage

// File: rtl/camera_poweroff_sequence_sm_if.sv
// Request / status / mask bundle of the camera power-off sequencer.
// PGOOD inputs exist only when CAM_PGOOD_CHECK_EN is defined.
interface camera_poweroff_sequence_sm_if;

    logic down_req_i;
    logic busy_o;
    logic done_o;
    logic inck_keep_o;
    logic xclr_keep_o;
    logic reg_3v3_keep_o;
    logic reg_1v8_keep_o;
    logic reg_1v2_keep_o;
    logic fault_o;
`ifdef CAM_PGOOD_CHECK_EN
    logic pgood_3v3_i;
    logic pgood_1v8_i;
    logic pgood_1v2_i;

    modport master (
        output down_req_i, pgood_3v3_i, pgood_1v8_i, pgood_1v2_i,
        input  busy_o, done_o, inck_keep_o, xclr_keep_o,
               reg_3v3_keep_o, reg_1v8_keep_o, reg_1v2_keep_o, fault_o
    );
    modport slave (
        input  down_req_i, pgood_3v3_i, pgood_1v8_i, pgood_1v2_i,
        output busy_o, done_o, inck_keep_o, xclr_keep_o,
               reg_3v3_keep_o, reg_1v8_keep_o, reg_1v2_keep_o, fault_o
    );
`else
    modport master (
        output down_req_i,
        input  busy_o, done_o, inck_keep_o, xclr_keep_o,
               reg_3v3_keep_o, reg_1v8_keep_o, reg_1v2_keep_o, fault_o
    );
    modport slave (
        input  down_req_i,
        output busy_o, done_o, inck_keep_o, xclr_keep_o,
               reg_3v3_keep_o, reg_1v8_keep_o, reg_1v2_keep_o, fault_o
    );
`endif

endinterface

// File: rtl/cam_step_delay_counter.sv
// Dwell / timeout counter: cleared on state entry, expired once it has run
// for eff_delay(delay) cycles.
module cam_step_delay_counter
    import camera_pwr_pkg::*;
(
    input  logic ctrl_clk_i,
    input  logic ctrl_rst_i,
    input  logic clear,
    input  logic enable,
    input  cnt_t delay,
    output logic expired
);

    cnt_t count;

    assign expired = (count >= eff_delay(delay) - cnt_t'(1));

    // NOTE: the count saturates at expiry so a long PGOOD wait can never wrap it.
    always_ff @(posedge ctrl_clk_i or posedge ctrl_rst_i) begin
        if (ctrl_rst_i) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + cnt_t'(1);
        end
    end

endmodule

// File: rtl/camera_poweroff_sequence_sm.sv
// Camera power-down sequencer: INCK off, XCLR low, 3V3, 1V8, 1V2 off, then DONE.
// Optional PGOOD-gated rail steps with timeout fault under CAM_PGOOD_CHECK_EN.
module camera_poweroff_sequence_sm
    import camera_pwr_pkg::*;
#(
    parameter cnt_t STEP_DELAY       = STEP_DELAY_DEF,
    parameter cnt_t XCLR_HOLD_CYCLES = XCLR_HOLD_DEF
`ifdef CAM_PGOOD_CHECK_EN
    ,
    parameter cnt_t FAULT_TIMEOUT    = FAULT_TIMEOUT_DEF
`endif
) (
    input logic ctrl_clk_i,
    input logic ctrl_rst_i,
    camera_poweroff_sequence_sm_if.slave bus
);

    pd_state_e state_q, state_d;
    pd_out_t   out_q, out_d;
    cnt_t      dwell_delay;
    logic      in_seq, state_chg, dwell_exp, step_done;

    assign dwell_delay = (state_q == PD_INCK_OFF) ? XCLR_HOLD_CYCLES : STEP_DELAY;
    assign in_seq      = state_q inside {[PD_INCK_OFF:PD_V12_OFF]};
    assign state_chg   = (state_d != state_q);

    cam_step_delay_counter u_dwell (
        .ctrl_clk_i (ctrl_clk_i),
        .ctrl_rst_i (ctrl_rst_i),
        .clear      (state_chg),
        .enable     (in_seq),
        .delay      (dwell_delay),
        .expired    (dwell_exp)
    );

`ifdef CAM_PGOOD_CHECK_EN
    logic rail_state, pgood_sel, to_exp, fault_q;

    assign rail_state = state_q inside {PD_V33_OFF, PD_V18_OFF, PD_V12_OFF};

    always_comb begin
        pgood_sel = 1'b0;
        case (state_q)
            PD_V33_OFF: pgood_sel = bus.pgood_3v3_i;
            PD_V18_OFF: pgood_sel = bus.pgood_1v8_i;
            PD_V12_OFF: pgood_sel = bus.pgood_1v2_i;
            default:    pgood_sel = 1'b0;
        endcase
    end

    cam_step_delay_counter u_timeout (
        .ctrl_clk_i (ctrl_clk_i),
        .ctrl_rst_i (ctrl_rst_i),
        .clear      (state_chg),
        .enable     (rail_state),
        .delay      (FAULT_TIMEOUT),
        .expired    (to_exp)
    );

    // A rail still reporting good at timeout is abandoned so the sequence always finishes.
    assign step_done = rail_state ? ((dwell_exp && !pgood_sel) || (to_exp && pgood_sel))
                                  : dwell_exp;

    always_ff @(posedge ctrl_clk_i or posedge ctrl_rst_i) begin
        if (ctrl_rst_i) begin
            fault_q <= 1'b0;
        end else if (rail_state && to_exp && pgood_sel) begin
            fault_q <= 1'b1;
        end
    end

    assign bus.fault_o = fault_q;
`else
    assign step_done   = dwell_exp;
    assign bus.fault_o = 1'b0;
`endif

    // NOTE: defaults first so no path through this block can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            PD_IDLE:     if (bus.down_req_i) state_d = PD_INCK_OFF;
            PD_INCK_OFF: if (step_done)      state_d = PD_XCLR_OFF;
            PD_XCLR_OFF: if (step_done)      state_d = PD_V33_OFF;
            PD_V33_OFF:  if (step_done)      state_d = PD_V18_OFF;
            PD_V18_OFF:  if (step_done)      state_d = PD_V12_OFF;
            PD_V12_OFF:  if (step_done)      state_d = PD_DONE;
            PD_DONE:                         state_d = PD_DONE;
            default:                         state_d = PD_IDLE;
        endcase

        // Masks are cumulative: once a state is reached every earlier mask stays low.
        out_d              = PD_OUT_RST;
        out_d.busy         = in_seq;
        out_d.done         = (state_q == PD_DONE);
        out_d.inck_keep    = (state_q < PD_INCK_OFF);
        out_d.xclr_keep    = (state_q < PD_XCLR_OFF);
        out_d.reg_3v3_keep = (state_q < PD_V33_OFF);
        out_d.reg_1v8_keep = (state_q < PD_V18_OFF);
        out_d.reg_1v2_keep = (state_q < PD_V12_OFF);
    end

    always_ff @(posedge ctrl_clk_i or posedge ctrl_rst_i) begin
        if (ctrl_rst_i) begin
            state_q <= PD_IDLE;
            out_q   <= PD_OUT_RST;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

    assign bus.busy_o         = out_q.busy;
    assign bus.done_o         = out_q.done;
    assign bus.inck_keep_o    = out_q.inck_keep;
    assign bus.xclr_keep_o    = out_q.xclr_keep;
    assign bus.reg_3v3_keep_o = out_q.reg_3v3_keep;
    assign bus.reg_1v8_keep_o = out_q.reg_1v8_keep;
    assign bus.reg_1v2_keep_o = out_q.reg_1v2_keep;

endmodule

// File: tb/tb_camera_poweroff_sequence_sm.sv
// Bench for camera_poweroff_sequence_sm: outputs checked every cycle against a
// schedule model built from the per-state dwell lengths.
module tb_camera_poweroff_sequence_sm;
    import camera_pwr_pkg::*;

    localparam int XH = 4;
    localparam int SD = 10;
`ifdef CAM_PGOOD_CHECK_EN
    localparam int FT = 20;
`endif

    logic ctrl_clk_i = 1'b0;
    logic ctrl_rst_i = 1'b1;

    camera_poweroff_sequence_sm_if bus ();

    camera_poweroff_sequence_sm #(
        .STEP_DELAY       (cnt_t'(SD)),
        .XCLR_HOLD_CYCLES (cnt_t'(XH))
`ifdef CAM_PGOOD_CHECK_EN
        ,
        .FAULT_TIMEOUT    (cnt_t'(FT))
`endif
    ) dut (
        .ctrl_clk_i (ctrl_clk_i),
        .ctrl_rst_i (ctrl_rst_i),
        .bus        (bus)
    );

    always #5 ctrl_clk_i = ~ctrl_clk_i;

    int   total = 0;
    int   bad   = 0;
    int   edge_n = 0;
    int   entry  = -1;   // edge at which the request was accepted, -1 when idle
    int   dur [5];       // cycles spent in INCK_OFF, XCLR_OFF, V33_OFF, V18_OFF, V12_OFF
    logic exp_fault = 1'b0;

    // Output vector: busy done fault inck xclr 3v3 1v8 1v2
    localparam logic [7:0] RST_OUT = 8'h1F;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", tag, edge_n, got, exp);
        end
    endtask

    function automatic logic [7:0] dut_out();
        return {bus.busy_o, bus.done_o, bus.fault_o, bus.inck_keep_o, bus.xclr_keep_o,
                bus.reg_3v3_keep_o, bus.reg_1v8_keep_o, bus.reg_1v2_keep_o};
    endfunction

    // Each mask drops one cycle after its state is entered; state i starts
    // sum(dur[0..i-1]) cycles after the accepting edge.
    function automatic logic [7:0] model_out(input int t);
        int d;
        int b [6];
        logic [7:0] o;
        if (entry < 0) return RST_OUT;
        d = t - entry;
        b[0] = 0;
        for (int i = 0; i < 5; i++) b[i+1] = b[i] + dur[i];
        o[7] = (d >= 1) && (d < b[5] + 1);
        o[6] = (d >= b[5] + 1);
        o[5] = exp_fault && (d >= b[3]);
        for (int i = 0; i < 5; i++) o[4-i] = (d < b[i] + 1);
        return o;
    endfunction

    task automatic step();
        @(posedge ctrl_clk_i);
        edge_n++;
        if (!ctrl_rst_i && entry < 0 && bus.down_req_i) entry = edge_n;
        #1;
        check("cycle", dut_out(), model_out(edge_n));
    endtask

    // Asserts reset between edges and checks the outputs fall back at once.
    task automatic async_reset(input string tag);
        bus.down_req_i = 1'b0;
        #2;
        ctrl_rst_i = 1'b1;
        entry = -1;
        #1;
        check(tag, dut_out(), RST_OUT);
        step();
        step();
        ctrl_rst_i = 1'b0;
    endtask

    initial begin
        int c0, inck_at, v12_at, done_at;
        bus.down_req_i = 1'b0;
`ifdef CAM_PGOOD_CHECK_EN
        bus.pgood_3v3_i = 1'b0;
        bus.pgood_1v8_i = 1'b0;
        bus.pgood_1v2_i = 1'b0;
`endif
        dur = '{XH, SD, SD, SD, SD};

        repeat (3) step();
        ctrl_rst_i = 1'b0;
        repeat (1000) step();
        check("idle_out", dut_out(), RST_OUT);

        // Pulse, a second pulse in V18_OFF, then held high in DONE.
        inck_at = -1; v12_at = -1; done_at = -1;
        c0 = edge_n;
        bus.down_req_i = 1'b1;
        for (int i = 0; i < 62; i++) begin
            step();
            if (!bus.inck_keep_o && inck_at < 0) inck_at = edge_n - c0;
            if (!bus.reg_1v2_keep_o && v12_at < 0) v12_at = edge_n - c0;
            if (bus.done_o && done_at < 0) done_at = edge_n - c0;
            bus.down_req_i = (i == 26) || (i >= 45);
        end
        check("inck_at", inck_at, 2);
        check("v12_at", v12_at, 36);
        check("done_at", done_at, 46);
        async_reset("rst_after_done");

        // Reset while in V33_OFF.
        bus.down_req_i = 1'b1;
        step();
        bus.down_req_i = 1'b0;
        repeat (17) step();
        check("v33_keep", bus.reg_3v3_keep_o, 1'b0);
        async_reset("rst_in_v33");

        for (int it = 0; it < 25; it++) begin
            int gap, width, extra, rst_at;
            logic hold;
            gap    = $urandom_range(15, 0);
            width  = $urandom_range(3, 1);
            extra  = $urandom_range(40, 5);
            hold   = 1'($urandom_range(1, 0));
            rst_at = ($urandom_range(1, 0) == 1) ? int'($urandom_range(55, 2)) : -1;
            repeat (gap) step();
            for (int i = 0; i < 60; i++) begin
                if (i == rst_at) break;
                bus.down_req_i = (i < width) || (i == extra) || (hold && i > 48);
                step();
            end
            async_reset("rand_rst");
        end

`ifdef CAM_PGOOD_CHECK_EN
        // 1V8 power-good drops five cycles after the V18_OFF dwell ends.
        dur[3] = SD + 5;
        bus.pgood_1v8_i = 1'b1;
        bus.down_req_i = 1'b1;
        for (int i = 0; i < 70; i++) begin
            step();
            bus.down_req_i = 1'b0;
            bus.pgood_1v8_i = (edge_n + 1 < entry + XH + 3 * SD + 5);
        end
        check("late_pg_fault", bus.fault_o, 1'b0);
        async_reset("rst_late_pg");
        dur[3] = SD;
        bus.pgood_1v8_i = 1'b0;

        // 3V3 power-good stuck high: timeout fault, sequence still completes.
        dur[2] = FT;
        exp_fault = 1'b1;
        bus.pgood_3v3_i = 1'b1;
        bus.down_req_i = 1'b1;
        for (int i = 0; i < 70; i++) begin
            step();
            bus.down_req_i = 1'b0;
        end
        check("stuck_fault", bus.fault_o, 1'b1);
        check("stuck_done", bus.done_o, 1'b1);
        async_reset("rst_stuck");
        exp_fault = 1'b0;
        dur[2] = SD;
        bus.pgood_3v3_i = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
